i2c_master_arbiter: RTL and testbench

Round-robin arbiter and transaction sequencer that shares one single-byte I2C master between `NREQ` client blocks. It sits between the clients and the master. It holds the master in reset while idle, releases it to run exactly one transaction for the granted client, and detects completion from the master's state output. It returns read data or a timeout error to the client.

---
 rtl/i2c_master_arbiter.sv | 166 ++++++++++++++++
 tb/tb_i2c_master_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_arbiter.sv
// Round-robin arbiter and sequencer sharing one single-byte I2C master among NREQ clients.
// Holds the master in reset while idle, releases it for one transaction, returns data or timeout.
module i2c_master_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ-1:0]   req_rw,
  input  logic [8*NREQ-1:0] req_wdata,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [7:0]        rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic              m_rst,
  output logic              m_rw,
  output logic [7:0]        m_wdata,
  input  logic [7:0]        m_rdata,
  input  logic [3:0]        m_state
);

  localparam int unsigned GW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, WAIT_DONE, RESP} state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   last_q, last_d;
  logic [GW-1:0]   g_q, g_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            m_rw_q, m_rw_d;
  logic [7:0]      m_wdata_q, m_wdata_d;
  logic [7:0]      rsp_rdata_q, rsp_rdata_d;
  logic            rsp_err_q, rsp_err_d;
  logic [NREQ-1:0] req_ready_q, req_ready_d;
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  logic            m_rst_q, m_rst_d;
  logic            busy_q, busy_d;

  logic            win_found;
  logic [GW-1:0]   win_idx;
  logic            win_rw;
  logic [7:0]      win_wdata;
  logic            timeout_hit;

  // Rotating priority: candidate k positions after the last served client, wrapping at NREQ.
  always_comb begin
    int unsigned cand;
    cand      = 0;
    win_found = 1'b0;
    win_idx   = '0;
    win_rw    = 1'b0;
    win_wdata = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = 32'(last_q) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (!win_found && (i == cand) && req_valid[i]) begin
          win_found = 1'b1;
          win_idx   = GW'(i);
          win_rw    = req_rw[i];
          win_wdata = req_wdata[8*i +: 8];
        end
      end
    end
  end

  // Counter holds cycles already spent; abort once the cycle being finished is the TIMEOUT-th.
  assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= GW'(NREQ - 1);
      g_q         <= '0;
      cnt_q       <= '0;
      m_rw_q      <= 1'b0;
      m_wdata_q   <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      m_rst_q     <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      g_q         <= g_d;
      cnt_q       <= cnt_d;
      m_rw_q      <= m_rw_d;
      m_wdata_q   <= m_wdata_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      m_rst_q     <= m_rst_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (win_found) state_d = LOAD;
      LOAD:      state_d = RUN;
      RUN: begin
        if (timeout_hit)           state_d = RESP;
        else if (m_state != '0)    state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (timeout_hit)           state_d = RESP;
        else if (m_state == '0)    state_d = RESP;
      end
      RESP:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Outputs are registered, so their next values are derived from the upcoming state.
  always_comb begin
    last_d      = last_q;
    g_d         = g_q;
    cnt_d       = cnt_q;
    m_rw_d      = m_rw_q;
    m_wdata_d   = m_wdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    req_ready_d = '0;
    rsp_valid_d = '0;
    m_rst_d     = !((state_d == RUN) || (state_d == WAIT_DONE));
    busy_d      = (state_d != IDLE);
    case (state_q)
      IDLE: begin
        if (win_found) begin
          g_d         = win_idx;
          m_rw_d      = win_rw;
          m_wdata_d   = win_wdata;
          req_ready_d = NREQ'(1) << win_idx;
        end
      end
      LOAD: cnt_d = '0;
      RUN, WAIT_DONE: begin
        cnt_d = cnt_q + CW'(1);
        if (state_d == RESP) begin
          rsp_valid_d = NREQ'(1) << g_q;
          rsp_err_d   = timeout_hit;
          rsp_rdata_d = (!timeout_hit && m_rw_q) ? m_rdata : '0;
        end
      end
      RESP: last_d = g_q;
      default: ;
    endcase
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = busy_q;
  assign m_rst     = m_rst_q;
  assign m_rw      = m_rw_q;
  assign m_wdata   = m_wdata_q;

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Self-checking bench for i2c_master_arbiter: fixed vectors, corner-case sequences and
// randomized transactions checked against a transaction-level model with a scripted master.
module tb_i2c_master_arbiter;
  localparam int unsigned NREQ = 4;
  localparam int unsigned TMO  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid, req_rw;
  logic [8*NREQ-1:0] req_wdata;
  logic [NREQ-1:0]   req_ready, rsp_valid;
  logic [7:0]        rsp_rdata, m_wdata, m_rdata;
  logic              rsp_err, busy, m_rst, m_rw;
  logic [3:0]        m_state;

  always #5 clk = ~clk;

  i2c_master_arbiter #(.NREQ(NREQ), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_rw(req_rw), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .busy(busy), .m_rst(m_rst), .m_rw(m_rw), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_state(m_state)
  );

  typedef struct {
    logic [3:0] vmask;
    logic       rw;
    logic [7:0] wd;
    int         len;
    logic [7:0] mrd;
    int         g;
    bit         err;
    logic [7:0] rd;
    int         lat;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  int mlen = 0;
  int mpos = 0;
  int rdy_cnt [NREQ];
  int rsp_cnt [NREQ];
  logic [3:0] pat [4] = '{4'd1, 4'd2, 4'd4, 4'd5};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_bound(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got no event within cycle budget, expected one", name);
  endtask

  // Advance one clock; the master model walks its scripted states only while released.
  task automatic tick();
    @(posedge clk);
    #1;
    if (m_rst !== 1'b0) begin
      mpos    = 0;
      m_state = '0;
    end else if (mpos < mlen) begin
      m_state = pat[mpos % 4];
      mpos++;
    end else begin
      m_state = '0;
    end
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i] === 1'b1) rdy_cnt[i]++;
      if (rsp_valid[i] === 1'b1) rsp_cnt[i]++;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
    chk({tag, "_rsp_err"},   rsp_err,   0);
    chk({tag, "_busy"},      busy,      0);
    chk({tag, "_m_rst"},     m_rst,     1);
    chk({tag, "_m_rw"},      m_rw,      0);
    chk({tag, "_m_wdata"},   m_wdata,   0);
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    req_valid = '0;
    tick();
    tick();
    #2 rst = 1'b0;
    tick();
  endtask

  // Present a request and run up to the first RUN cycle.
  task automatic start_txn(input logic [3:0] vmask, input logic rw, input logic [7:0] wd,
                           input int len, input logic [7:0] mrd, input int exp_g, output bit ok);
    logic [7:0] exp_wd;
    req_valid = vmask;
    req_rw    = {NREQ{rw}};
    for (int i = 0; i < NREQ; i++) req_wdata[8*i +: 8] = wd + 8'(i);
    m_rdata = mrd;
    exp_wd  = wd + 8'(exp_g);
    ok = 1'b0;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (req_ready !== '0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      fail_bound("grant_wait");
      req_valid = '0;
      return;
    end
    chk("grant_onehot", req_ready, 32'(1) << exp_g);
    chk("load_m_rw",    m_rw, rw);
    chk("load_m_wdata", m_wdata, exp_wd);
    chk("load_m_rst",   m_rst, 1);
    chk("load_busy",    busy, 1);
    mlen      = len;
    req_valid = '0;
    req_rw    = ~req_rw;
    req_wdata = ~req_wdata;
    tick();
    chk("run_m_rst",    m_rst, 0);
    chk("ready_pulse",  req_ready, 0);
    chk("hold_m_wdata", m_wdata, exp_wd);
    chk("hold_m_rw",    m_rw, rw);
  endtask

  // n_start = cycles since LOAD already elapsed (1 = now in first RUN cycle).
  task automatic finish_txn(input int exp_g, input bit exp_err, input logic [7:0] exp_rd,
                            input int exp_lat, input int n_start);
    int  n    = n_start;
    int  lows = n_start - 1;
    bit  seen = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (rsp_valid !== '0) begin
        seen = 1'b1;
        break;
      end
      if (m_rst === 1'b0) lows++;
      tick();
      n++;
    end
    if (!seen) begin
      fail_bound("rsp_wait");
      return;
    end
    chk("rsp_latency",   n, exp_lat);
    chk("rsp_onehot",    rsp_valid, 32'(1) << exp_g);
    chk("rsp_err",       rsp_err, exp_err);
    chk("rsp_rdata",     rsp_rdata, exp_rd);
    chk("resp_m_rst",    m_rst, 1);
    chk("m_rst_low_cyc", lows, exp_lat - 1);
    tick();
    chk("rsp_pulse",     rsp_valid, 0);
    chk("idle_busy",     busy, 0);
    chk("idle_m_rst",    m_rst, 1);
    chk("hold_rdata",    rsp_rdata, exp_rd);
    chk("hold_err",      rsp_err, exp_err);
  endtask

  task automatic do_txn(input vec_t v);
    bit ok;
    start_txn(v.vmask, v.rw, v.wd, v.len, v.mrd, v.g, ok);
    if (ok) finish_txn(v.g, v.err, v.rd, v.lat, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vt [8];
    vec_t v;
    bit   ok;
    int   grants [$];
    int   hi_run, r1, s1, rsp_total;
    int   exp_order [5] = '{0, 1, 2, 3, 0};
    int   mdl_last;

    vt[0] = '{4'b0100, 1'b0, 8'hA5, 4,  8'h77, 2, 1'b0, 8'h00, 6};
    vt[1] = '{4'b0001, 1'b1, 8'h00, 3,  8'h3C, 0, 1'b0, 8'h3C, 5};
    vt[2] = '{4'b1011, 1'b1, 8'h40, 1,  8'hC3, 1, 1'b0, 8'hC3, 3};
    vt[3] = '{4'b0001, 1'b0, 8'h5A, 14, 8'hFF, 0, 1'b0, 8'h00, 16};
    vt[4] = '{4'b1000, 1'b1, 8'h00, 15, 8'h99, 3, 1'b1, 8'h00, 17};
    vt[5] = '{4'b0110, 1'b1, 8'h00, 0,  8'h11, 1, 1'b1, 8'h00, 17};
    vt[6] = '{4'b1001, 1'b1, 8'h00, 2,  8'h5E, 3, 1'b0, 8'h5E, 4};
    vt[7] = '{4'b0101, 1'b0, 8'hE0, 20, 8'hAA, 0, 1'b1, 8'h00, 17};

    for (int i = 0; i < NREQ; i++) begin
      rdy_cnt[i] = 0;
      rsp_cnt[i] = 0;
    end
    rst = 1'b1; req_valid = '0; req_rw = '0; req_wdata = '0; m_rdata = '0; m_state = '0;
    tick();
    chk_reset_vals("por");
    #2 rst = 1'b0;
    tick();
    chk_reset_vals("idle");

    for (int i = 0; i < 8; i++) do_txn(vt[i]);

    // Withdrawn request: client 1 pulses valid while client 0's transaction runs.
    r1 = rdy_cnt[1];
    s1 = rsp_cnt[1];
    start_txn(4'b0001, 1'b1, 8'h00, 6, 8'h6B, 0, ok);
    if (ok) begin
      tick();
      req_valid[1] = 1'b1;
      tick();
      req_valid[1] = 1'b0;
      finish_txn(0, 1'b0, 8'h6B, 8, 3);
    end
    for (int i = 0; i < 10; i++) tick();
    chk("withdrawn_ready", rdy_cnt[1] - r1, 0);
    chk("withdrawn_rsp",   rsp_cnt[1] - s1, 0);
    chk("withdrawn_busy",  busy, 0);

    // Reset mid-transaction, after a completed read leaves non-reset data behind.
    v = '{4'b0010, 1'b1, 8'h00, 2, 8'h21, 1, 1'b0, 8'h21, 4};
    do_txn(v);
    start_txn(4'b0100, 1'b1, 8'h90, 30, 8'h55, 2, ok);
    for (int i = 0; i < 5; i++) tick();
    chk("pre_rst_busy", busy, 1);
    rsp_total = rsp_cnt[0] + rsp_cnt[1] + rsp_cnt[2] + rsp_cnt[3];
    #2 rst = 1'b1;
    #1 chk_reset_vals("async_rst");
    tick();
    tick();
    #2 rst = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    chk("rst_no_rsp", rsp_cnt[0] + rsp_cnt[1] + rsp_cnt[2] + rsp_cnt[3], rsp_total);
    v = '{4'b1101, 1'b1, 8'h00, 3, 8'hD2, 0, 1'b0, 8'hD2, 5};
    do_txn(v);

    // Round-robin with all four requests held continuously from reset.
    do_reset();
    req_valid = '1; req_rw = '0; req_wdata = 32'h3322_1100; mlen = 2;
    hi_run = 0;
    for (int c = 0; c < 300 && grants.size() < 5; c++) begin
      tick();
      if (m_rst === 1'b1) hi_run++;
      else hi_run = 0;
      if (req_ready !== '0) begin
        chk("rr_onehot", $countones(req_ready), 1);
        for (int i = 0; i < NREQ; i++) if (req_ready[i] === 1'b1) grants.push_back(i);
        if (grants.size() > 1) chk("rr_m_rst_gap", hi_run >= 3, 1);
      end
    end
    req_valid = '0;
    if (grants.size() < 5) fail_bound("rr_grants");
    for (int i = 0; i < 5 && i < grants.size(); i++) chk("rr_order", grants[i], exp_order[i]);
    for (int c = 0; c < 60 && busy !== 1'b0; c++) tick();
    chk("rr_drain", busy, 0);

    // Randomized transactions against a transaction-level model.
    do_reset();
    mdl_last = NREQ - 1;
    for (int t = 0; t < 40; t++) begin
      v.vmask = 4'($urandom_range(1, 15));
      v.rw    = 1'($urandom_range(0, 1));
      v.wd    = 8'($urandom);
      v.len   = $urandom_range(0, 20);
      v.mrd   = 8'($urandom);
      v.g     = -1;
      for (int k = 1; k <= NREQ; k++) begin
        int c;
        c = (mdl_last + k) % NREQ;
        if (v.g < 0 && v.vmask[c]) v.g = c;
      end
      v.err = (v.len == 0) || (v.len + 1 >= TMO);
      v.lat = v.err ? TMO + 1 : v.len + 2;
      v.rd  = (v.rw && !v.err) ? v.mrd : 8'h00;
      do_txn(v);
      mdl_last = v.g;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
